// File: rtl/dmem_io.sv
// Data-side memory stage behind the single-cycle core: word RAM, a cycle counter
// and an output FIFO drained through a valid/ready console port.
module dmem_io #(
  parameter int RAM_WORDS  = 64,
  parameter int FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        memwrite,
  input  logic [31:0] aluout,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic [31:0] out_data,
  output logic        out_valid,
  input  logic        out_ready
);
  localparam int AW = $clog2(RAM_WORDS);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  localparam logic [29:0] CYC_W  = 30'h3FFF_C000;
  localparam logic [29:0] STAT_W = 30'h3FFF_C001;
  localparam logic [29:0] PUSH_W = 30'h3FFF_C002;

  logic [31:0]   ram [RAM_WORDS];
  logic [31:0]   fifo_mem [FIFO_DEPTH];
  logic [31:0]   cycle;
  logic [PW-1:0] rd_ptr, wr_ptr, rd_ptr_n;
  logic [CW-1:0] count, count_n;
  logic          overflow;
  logic [31:0]   head_q;

  logic ram_hit, cyc_hit, stat_hit, push_hit;
  logic full, empty, pop, push_req, push, ovf_set;
  logic [AW-1:0] ram_idx;
  logic [7:0]    cnt8;
  logic [31:0]   status;
  logic          unused;

  assign ram_hit  = (aluout[31:28] == 4'h0);
  assign cyc_hit  = (aluout[31:2] == CYC_W);
  assign stat_hit = (aluout[31:2] == STAT_W);
  assign push_hit = (aluout[31:2] == PUSH_W);
  assign ram_idx  = aluout[AW+1:2];
  assign unused   = ^{aluout[27:AW+2], aluout[1:0]};

  assign empty     = (count == '0);
  assign full      = (count == CW'(FIFO_DEPTH));
  assign out_valid = !empty;
  assign out_data  = head_q;
  assign pop       = out_valid && out_ready;
  assign push_req  = memwrite && push_hit;
  // A full FIFO still takes the push when the head leaves in the same cycle.
  assign push      = push_req && (!full || pop);
  assign ovf_set   = push_req && full && !pop;
  assign count_n   = count + CW'(push) - CW'(pop);
  assign rd_ptr_n  = pop ? rd_ptr + PW'(1) : rd_ptr;

  assign cnt8   = 8'(count);
  assign status = {16'h0, cnt8, 5'h0, overflow, full, empty};

  always_comb begin
    readdata = '0;
    if (ram_hit)       readdata = ram[ram_idx];
    else if (cyc_hit)  readdata = cycle;
    else if (stat_hit) readdata = status;
    if (!reset)        readdata = '0;
  end

  always_ff @(posedge clk) begin
    if (memwrite && ram_hit) ram[ram_idx] <= writedata;
    if (push) fifo_mem[wr_ptr] <= writedata;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cycle    <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
      head_q   <= '0;
    end else begin
      cycle  <= (memwrite && cyc_hit) ? writedata : cycle + 32'd1;
      rd_ptr <= rd_ptr_n;
      count  <= count_n;
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (ovf_set)                                       overflow <= 1'b1;
      else if (memwrite && stat_hit && writedata[2])     overflow <= 1'b0;
      // Head register tracks the word at the new read pointer, bypassing a
      // push that lands exactly there; it holds its value once the FIFO drains.
      if (count_n != '0)
        head_q <= (push && (wr_ptr == rd_ptr_n)) ? writedata : fifo_mem[rd_ptr_n];
    end
  end
endmodule
